// File: rtl/serdes_lane_pkg.sv
// Shared types and constants for the SERDES lane bring-up controller.
package serdes_lane_pkg;

    typedef enum logic [2:0] {
        StOff       = 3'd0,
        StPwrup     = 3'd1,
        StWaitLock  = 3'd2,
        StWaitReady = 3'd3,
        StUp        = 3'd4,
        StFault     = 3'd5
    } lane_state_t;

    localparam logic [12:0] OfsCtrl      = 13'h0;
    localparam logic [12:0] OfsStatus    = 13'h1;
    localparam logic [12:0] OfsIntStat   = 13'h2;
    localparam logic [12:0] OfsIntEn     = 13'h3;
    localparam logic [12:0] OfsLaneState = 13'h4;

    localparam int unsigned IntLockRise   = 0;
    localparam int unsigned IntLockFall   = 1;
    localparam int unsigned IntFaultLsb   = 8;
    localparam int unsigned CtrlAutoRetry = 16;
    localparam int unsigned CtrlPhyEn     = 17;
    localparam int unsigned StatusLock    = 31;

endpackage

// File: rtl/serdes_lane_fsm.sv
// One EPCS lane: power/reset sequencer with shared timeout counter and ready synchroniser.
module serdes_lane_fsm
    import serdes_lane_pkg::*;
#(
    parameter int unsigned RST_HOLD_CYC  = 16,
    parameter int unsigned LOCK_WAIT_CYC = 1024,
    parameter int unsigned CNT_W         = $clog2(LOCK_WAIT_CYC + 1)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        lane_en,
    input  logic        auto_retry,
    input  logic        lock_sync,
    input  logic        epcs_ready,
    output lane_state_t state,
    output logic        pwrdn,
    output logic        rstn,
    output logic        lane_up,
    output logic        fault,
    output logic        fault_entry
);

    localparam logic [CNT_W-1:0] HoldLoad = CNT_W'(RST_HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] WaitLoad = CNT_W'(LOCK_WAIT_CYC - 1);

    lane_state_t      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ready_meta_q, ready_sync_q;
    logic             fault_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StOff;
            cnt_q        <= '0;
            ready_meta_q <= 1'b0;
            ready_sync_q <= 1'b0;
            fault_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            ready_meta_q <= epcs_ready;
            ready_sync_q <= ready_meta_q;
            if (!lane_en) begin
                fault_q <= 1'b0;
            end else if (fault_entry) begin
                fault_q <= 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = (cnt_q == '0) ? '0 : cnt_q - 1'b1;
        if (!lane_en) begin
            state_d = StOff;
            cnt_d   = HoldLoad;
        end else begin
            case (state_q)
                StOff: begin
                    state_d = StPwrup;
                    cnt_d   = HoldLoad;
                end
                StPwrup: begin
                    if (cnt_q == '0) begin
                        state_d = StWaitLock;
                        cnt_d   = WaitLoad;
                    end
                end
                StWaitLock: begin
                    if (lock_sync) begin
                        state_d = StWaitReady;
                        cnt_d   = WaitLoad;
                    end else if (cnt_q == '0) begin
                        state_d = StFault;
                        cnt_d   = HoldLoad;
                    end
                end
                StWaitReady: begin
                    // Losing lock outranks both ready and timeout
                    if (!lock_sync) begin
                        state_d = StWaitLock;
                        cnt_d   = WaitLoad;
                    end else if (ready_sync_q) begin
                        state_d = StUp;
                    end else if (cnt_q == '0) begin
                        state_d = StFault;
                        cnt_d   = HoldLoad;
                    end
                end
                StUp: begin
                    if (!lock_sync) begin
                        state_d = StWaitLock;
                        cnt_d   = WaitLoad;
                    end else if (!ready_sync_q) begin
                        state_d = StWaitReady;
                        cnt_d   = WaitLoad;
                    end
                end
                StFault: begin
                    if (auto_retry && cnt_q == '0) begin
                        state_d = StPwrup;
                        cnt_d   = HoldLoad;
                    end
                end
                default: begin
                    state_d = StOff;
                    cnt_d   = HoldLoad;
                end
            endcase
        end
    end

    assign fault_entry = (state_q != StFault) && (state_d == StFault);
    assign state       = state_q;
    assign pwrdn       = (state_q == StOff);
    assign rstn        = (state_q == StWaitReady) || (state_q == StUp);
    assign lane_up     = (state_q == StUp);
    assign fault       = fault_q;

endmodule

// File: rtl/serdes_lane_ctrl.sv
// APB register front-end, SPLL lock synchroniser/edge detect and interrupts for the lane FSMs.
module serdes_lane_ctrl
    import serdes_lane_pkg::*;
#(
    parameter int unsigned NUM_LANES     = 4,
    parameter int unsigned RST_HOLD_CYC  = 16,
    parameter int unsigned LOCK_WAIT_CYC = 1024,
    parameter int unsigned CNT_W         = $clog2(LOCK_WAIT_CYC + 1)
) (
    input  logic                 APB_CLK,
    input  logic                 APB_RST,
    input  logic [14:2]          APB_PADDR,
    input  logic                 APB_PSEL,
    input  logic                 APB_PENABLE,
    input  logic                 APB_PWRITE,
    input  logic [31:0]          APB_PWDATA,
    output logic [31:0]          APB_PRDATA,
    output logic                 APB_PREADY,
    output logic                 APB_PSLVERR,
    input  logic                 SPLL_LOCK,
    input  logic [NUM_LANES-1:0] EPCS_READY,
    output logic [NUM_LANES-1:0] EPCS_PWRDN,
    output logic [NUM_LANES-1:0] EPCS_RSTN,
    output logic                 SERDESIF_PHY_RESET_N,
    output logic [NUM_LANES-1:0] LANE_UP,
    output logic                 PLL_LOCK_INT,
    output logic                 PLL_LOCKLOST_INT,
    output logic                 IRQ
);

    localparam logic [31:0] IntMask =
        32'h3 | (((32'h1 << NUM_LANES) - 32'h1) << IntFaultLsb);

    logic [NUM_LANES-1:0]   lane_en_q;
    logic                   auto_retry_q, phy_en_q;
    logic [31:0]            int_stat_q, int_stat_d, int_en_q, int_set;
    logic                   lock_meta_q, lock_sync_q, lock_prev_q;
    logic                   lock_rise, lock_fall;
    logic [NUM_LANES-1:0]   lane_up, lane_fault, fault_entry, pwrdn, rstn;
    logic [3*NUM_LANES-1:0] lane_state_vec;
    logic                   access, wr, addr_valid, ro_hit;
    logic [31:0]            rdata;

    assign access = APB_PSEL & APB_PENABLE;
    assign wr     = access & APB_PWRITE;

    always_comb begin
        addr_valid = 1'b1;
        ro_hit     = 1'b0;
        rdata      = '0;
        case (APB_PADDR)
            OfsCtrl: begin
                rdata                = 32'(lane_en_q);
                rdata[CtrlAutoRetry] = auto_retry_q;
                rdata[CtrlPhyEn]     = phy_en_q;
            end
            OfsStatus: begin
                ro_hit            = 1'b1;
                rdata             = 32'(lane_up);
                rdata[15:8]       = 8'(lane_fault);
                rdata[StatusLock] = lock_sync_q;
            end
            OfsIntStat: rdata = int_stat_q;
            OfsIntEn:   rdata = int_en_q;
            OfsLaneState: begin
                ro_hit = 1'b1;
                rdata  = 32'(lane_state_vec);
            end
            default: addr_valid = 1'b0;
        endcase
    end

    assign APB_PREADY  = 1'b1;
    assign APB_PSLVERR = access & (~addr_valid | (APB_PWRITE & ro_hit));
    assign APB_PRDATA  = (access & ~APB_PWRITE & addr_valid) ? rdata : '0;

    assign lock_rise = lock_sync_q & ~lock_prev_q;
    assign lock_fall = ~lock_sync_q & lock_prev_q;
    assign int_set   = (32'(fault_entry) << IntFaultLsb)
                     | (32'(lock_rise) << IntLockRise)
                     | (32'(lock_fall) << IntLockFall);

    // Clear first, then set, so a hardware event beats a same-cycle W1C
    always_comb begin
        int_stat_d = int_stat_q;
        if (wr && APB_PADDR == OfsIntStat) begin
            int_stat_d = int_stat_d & ~APB_PWDATA;
        end
        int_stat_d = (int_stat_d | int_set) & IntMask;
    end

    always_ff @(posedge APB_CLK or posedge APB_RST) begin
        if (APB_RST) begin
            lane_en_q    <= '0;
            auto_retry_q <= 1'b0;
            phy_en_q     <= 1'b0;
            int_stat_q   <= '0;
            int_en_q     <= '0;
            lock_meta_q  <= 1'b0;
            lock_sync_q  <= 1'b0;
            lock_prev_q  <= 1'b0;
        end else begin
            lock_meta_q <= SPLL_LOCK;
            lock_sync_q <= lock_meta_q;
            lock_prev_q <= lock_sync_q;
            int_stat_q  <= int_stat_d;
            if (wr && APB_PADDR == OfsCtrl) begin
                lane_en_q    <= APB_PWDATA[NUM_LANES-1:0];
                auto_retry_q <= APB_PWDATA[CtrlAutoRetry];
                phy_en_q     <= APB_PWDATA[CtrlPhyEn];
            end
            if (wr && APB_PADDR == OfsIntEn) begin
                int_en_q <= APB_PWDATA & IntMask;
            end
        end
    end

    for (genvar n = 0; n < NUM_LANES; n++) begin : g_lane
        lane_state_t st;
        serdes_lane_fsm #(
            .RST_HOLD_CYC (RST_HOLD_CYC),
            .LOCK_WAIT_CYC(LOCK_WAIT_CYC),
            .CNT_W        (CNT_W)
        ) u_lane (
            .clk        (APB_CLK),
            .rst        (APB_RST),
            .lane_en    (lane_en_q[n]),
            .auto_retry (auto_retry_q),
            .lock_sync  (lock_sync_q),
            .epcs_ready (EPCS_READY[n]),
            .state      (st),
            .pwrdn      (pwrdn[n]),
            .rstn       (rstn[n]),
            .lane_up    (lane_up[n]),
            .fault      (lane_fault[n]),
            .fault_entry(fault_entry[n])
        );
        assign lane_state_vec[3*n +: 3] = st;
    end

    assign EPCS_PWRDN           = pwrdn;
    assign EPCS_RSTN            = rstn;
    assign LANE_UP              = lane_up;
    assign SERDESIF_PHY_RESET_N = phy_en_q;
    assign PLL_LOCK_INT         = int_stat_q[IntLockRise] & int_en_q[IntLockRise];
    assign PLL_LOCKLOST_INT     = int_stat_q[IntLockFall] & int_en_q[IntLockFall];
    assign IRQ                  = |(int_stat_q & int_en_q);

endmodule

// File: tb/tb_serdes_lane_ctrl.sv
// Directed bench for serdes_lane_ctrl with 4 lanes and default timing parameters.
module tb_serdes_lane_ctrl;

    logic        clk, rst;
    logic [14:2] paddr;
    logic        psel, penable, pwrite;
    logic [31:0] pwdata, prdata;
    logic        pready, pslverr, spll_lock;
    logic [3:0]  epcs_ready, pwrdn, rstn, lane_up;
    logic        phy_rst_n, lock_int, locklost_int, irq;

    int          n_vec, n_err;
    logic [31:0] rd;
    logic        err;

    serdes_lane_ctrl dut (
        .APB_CLK             (clk),
        .APB_RST             (rst),
        .APB_PADDR           (paddr),
        .APB_PSEL            (psel),
        .APB_PENABLE         (penable),
        .APB_PWRITE          (pwrite),
        .APB_PWDATA          (pwdata),
        .APB_PRDATA          (prdata),
        .APB_PREADY          (pready),
        .APB_PSLVERR         (pslverr),
        .SPLL_LOCK           (spll_lock),
        .EPCS_READY          (epcs_ready),
        .EPCS_PWRDN          (pwrdn),
        .EPCS_RSTN           (rstn),
        .SERDESIF_PHY_RESET_N(phy_rst_n),
        .LANE_UP             (lane_up),
        .PLL_LOCK_INT        (lock_int),
        .PLL_LOCKLOST_INT    (locklost_int),
        .IRQ                 (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Commit edge is the second posedge after the call; returns 1 time unit after it.
    task automatic apb_write(input logic [12:0] ofs, input logic [31:0] d, output logic e);
        @(negedge clk);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = ofs; pwdata = d;
        @(negedge clk);
        penable = 1'b1;
        #1;
        e = pslverr;
        @(posedge clk);
        #1;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    task automatic apb_read(input logic [12:0] ofs, output logic [31:0] d, output logic e);
        @(negedge clk);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = ofs;
        @(negedge clk);
        penable = 1'b1;
        #1;
        d = prdata;
        e = pslverr;
        @(posedge clk);
        #1;
        psel = 1'b0; penable = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; psel = 0; penable = 0; pwrite = 0; paddr = '0; pwdata = '0;
        spll_lock = 1'b0; epcs_ready = 4'h0;
        tick(3);
        n_vec++;
        if ({pwrdn, rstn, lane_up, phy_rst_n, lock_int, locklost_int, irq, pready, pslverr}
            !== {4'hF, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0}) begin
            n_err++;
            $display("FAIL reset_outputs: pwrdn=%h rstn=%h up=%h phy=%b ints=%b%b%b rdy=%b err=%b",
                     pwrdn, rstn, lane_up, phy_rst_n, lock_int, locklost_int, irq, pready, pslverr);
        end
        n_vec++;
        if (prdata !== 32'h0) begin
            n_err++; $display("FAIL reset_prdata: got %h want 0", prdata);
        end
        rst = 1'b0;
        tick(2);
        apb_read(13'h0, rd, err);
        n_vec++;
        if (rd !== 32'h0 || err !== 1'b0) begin
            n_err++; $display("FAIL reset_ctrl: got %h err %b want 0 err 0", rd, err);
        end
        apb_read(13'h1, rd, err);
        n_vec++;
        if (rd !== 32'h0) begin
            n_err++; $display("FAIL reset_status: got %h want 0", rd);
        end
        apb_read(13'h2, rd, err);
        n_vec++;
        if (rd !== 32'h0) begin
            n_err++; $display("FAIL reset_int_stat: got %h want 0", rd);
        end
        apb_read(13'h4, rd, err);
        n_vec++;
        if (rd !== 32'h0) begin
            n_err++; $display("FAIL reset_lane_state: got %h want 0", rd);
        end
        // CTRL lane_en bits above lane 3 read back as zero
        apb_write(13'h0, 32'h0000_00F0, err);
        apb_read(13'h0, rd, err);
        n_vec++;
        if (rd !== 32'h0) begin
            n_err++; $display("FAIL ctrl_upper_lanes: got %h want 0", rd);
        end
    endtask

    task automatic test_bring_up;
        apb_write(13'h0, 32'h0002_000F, err);
        tick(40);
        n_vec++;
        if ({pwrdn, rstn, phy_rst_n} !== {4'h0, 4'h0, 1'b1}) begin
            n_err++; $display("FAIL bringup_wait_lock: pwrdn=%h rstn=%h phy=%b want 0 0 1",
                              pwrdn, rstn, phy_rst_n);
        end
        spll_lock = 1'b1;
        tick(2);
        n_vec++;
        if (rstn !== 4'h0) begin
            n_err++; $display("FAIL bringup_rstn_lock2: got %h want 0", rstn);
        end
        tick(1);
        n_vec++;
        if (rstn !== 4'hF) begin
            n_err++; $display("FAIL bringup_rstn_lock3: got %h want f", rstn);
        end
        tick(37);
        epcs_ready = 4'hF;
        tick(2);
        n_vec++;
        if (lane_up !== 4'h0) begin
            n_err++; $display("FAIL bringup_up_ready2: got %h want 0", lane_up);
        end
        tick(1);
        n_vec++;
        if (lane_up !== 4'hF || irq !== 1'b0) begin
            n_err++; $display("FAIL bringup_up_ready3: up %h irq %b want f 0", lane_up, irq);
        end
        apb_read(13'h2, rd, err);
        n_vec++;
        if (rd !== 32'h1) begin
            n_err++; $display("FAIL bringup_int_stat: got %h want 1", rd);
        end
        apb_read(13'h1, rd, err);
        n_vec++;
        if (rd !== 32'h8000_000F) begin
            n_err++; $display("FAIL bringup_status: got %h want 8000000f", rd);
        end
        apb_read(13'h4, rd, err);
        n_vec++;
        if (rd !== 32'h924) begin
            n_err++; $display("FAIL bringup_lane_state: got %h want 924", rd);
        end
    endtask

    task automatic test_lock_loss;
        spll_lock = 1'b0;
        tick(2);
        n_vec++;
        if (rstn !== 4'hF) begin
            n_err++; $display("FAIL lockloss_rstn2: got %h want f", rstn);
        end
        tick(1);
        n_vec++;
        if (rstn !== 4'h0 || lane_up !== 4'h0) begin
            n_err++; $display("FAIL lockloss_rstn3: rstn %h up %h want 0 0", rstn, lane_up);
        end
        tick(7);
        spll_lock = 1'b1;
        tick(8);
        n_vec++;
        if (lane_up !== 4'hF) begin
            n_err++; $display("FAIL lockloss_recover: got %h want f", lane_up);
        end
        apb_read(13'h2, rd, err);
        n_vec++;
        if (rd !== 32'h3) begin
            n_err++; $display("FAIL lockloss_int_stat: got %h want 3", rd);
        end
    endtask

    task automatic test_w1c_race;
        apb_write(13'h3, 32'h2, err);
        apb_write(13'h2, 32'h3, err);
        apb_read(13'h2, rd, err);
        n_vec++;
        if (rd !== 32'h0 || locklost_int !== 1'b0) begin
            n_err++; $display("FAIL w1c_clear: got %h int %b want 0 0", rd, locklost_int);
        end
        spll_lock = 1'b0;
        tick(1);
        apb_write(13'h2, 32'h2, err);  // commits on the edge the lock fall is recorded
        apb_read(13'h2, rd, err);
        n_vec++;
        if (rd !== 32'h2) begin
            n_err++; $display("FAIL w1c_race: got %h want 2", rd);
        end
        n_vec++;
        if ({locklost_int, irq, lock_int} !== 3'b110) begin
            n_err++; $display("FAIL w1c_race_irq: got %b want 110", {locklost_int, irq, lock_int});
        end
        spll_lock = 1'b1;
        tick(12);
        n_vec++;
        if (lane_up !== 4'hF) begin
            n_err++; $display("FAIL w1c_recover: got %h want f", lane_up);
        end
        apb_write(13'h3, 32'h0, err);
    endtask

    task automatic test_fault;
        apb_write(13'h0, 32'h0002_0000, err);
        spll_lock = 1'b0;
        tick(5);
        apb_write(13'h2, 32'hFFFF_FFFF, err);
        apb_read(13'h1, rd, err);
        n_vec++;
        if (rd !== 32'h0) begin
            n_err++; $display("FAIL fault_pre_status: got %h want 0", rd);
        end
        apb_write(13'h0, 32'h0002_0004, err);
        tick(1039);
        apb_read(13'h1, rd, err);
        n_vec++;
        if (rd !== 32'h0) begin
            n_err++; $display("FAIL fault_not_yet: got %h want 0", rd);
        end
        apb_read(13'h1, rd, err);
        n_vec++;
        if (rd !== 32'h400) begin
            n_err++; $display("FAIL fault_status: got %h want 400", rd);
        end
        apb_read(13'h2, rd, err);
        n_vec++;
        if (rd !== 32'h400 || irq !== 1'b0) begin
            n_err++; $display("FAIL fault_int_stat: got %h irq %b want 400 0", rd, irq);
        end
        n_vec++;
        if (pwrdn !== 4'b1011 || rstn !== 4'h0) begin
            n_err++; $display("FAIL fault_pins: pwrdn %h rstn %h want b 0", pwrdn, rstn);
        end
        apb_read(13'h4, rd, err);
        n_vec++;
        if (rd !== 32'h140) begin
            n_err++; $display("FAIL fault_lane_state: got %h want 140", rd);
        end
        apb_write(13'h3, 32'h400, err);
        n_vec++;
        if (irq !== 1'b1 || lock_int !== 1'b0) begin
            n_err++; $display("FAIL fault_irq: irq %b lock_int %b want 1 0", irq, lock_int);
        end
    endtask

    task automatic test_auto_retry;
        apb_write(13'h3, 32'h0, err);
        apb_write(13'h0, 32'h0002_0000, err);
        tick(2);
        apb_write(13'h0, 32'h0003_0004, err);
        tick(1055);
        apb_read(13'h4, rd, err);
        n_vec++;
        if (rd !== 32'h140) begin
            n_err++; $display("FAIL retry_in_fault: got %h want 140", rd);
        end
        apb_read(13'h4, rd, err);
        n_vec++;
        if (rd !== 32'h040) begin
            n_err++; $display("FAIL retry_pwrup: got %h want 40", rd);
        end
        spll_lock = 1'b1;
        tick(20);
        n_vec++;
        if (lane_up !== 4'h4) begin
            n_err++; $display("FAIL retry_up: got %h want 4", lane_up);
        end
        apb_read(13'h1, rd, err);
        n_vec++;
        if (rd !== 32'h8000_0404) begin
            n_err++; $display("FAIL retry_status: got %h want 80000404", rd);
        end
    endtask

    task automatic test_errors_and_reset;
        apb_read(13'h7, rd, err);
        n_vec++;
        if (err !== 1'b1 || rd !== 32'h0) begin
            n_err++; $display("FAIL err_unmapped: err %b data %h want 1 0", err, rd);
        end
        apb_write(13'h1, 32'hFFFF_FFFF, err);
        n_vec++;
        if (err !== 1'b1) begin
            n_err++; $display("FAIL err_wr_status: got %b want 1", err);
        end
        apb_write(13'h4, 32'hFFFF_FFFF, err);
        n_vec++;
        if (err !== 1'b1) begin
            n_err++; $display("FAIL err_wr_lane_state: got %b want 1", err);
        end
        apb_read(13'h1, rd, err);
        n_vec++;
        if (rd !== 32'h8000_0404 || err !== 1'b0) begin
            n_err++; $display("FAIL err_status_kept: got %h err %b want 80000404 0", rd, err);
        end
        epcs_ready = 4'h0;
        tick(5);
        apb_read(13'h4, rd, err);
        n_vec++;
        if (rd !== 32'h0C0 || rstn !== 4'h4) begin
            n_err++; $display("FAIL err_wait_ready: state %h rstn %h want c0 4", rd, rstn);
        end
        apb_write(13'h3, 32'h3, err);
        n_vec++;
        if (irq !== 1'b1 || lock_int !== 1'b1) begin
            n_err++; $display("FAIL err_pre_rst_irq: irq %b lock_int %b want 1 1", irq, lock_int);
        end
        #3;
        rst = 1'b1;
        #1;
        n_vec++;
        if ({pwrdn, rstn, lane_up, phy_rst_n, lock_int, locklost_int, irq, pready, pslverr}
            !== {4'hF, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0}) begin
            n_err++;
            $display("FAIL async_rst_outputs: pwrdn=%h rstn=%h up=%h phy=%b ints=%b%b%b rdy=%b",
                     pwrdn, rstn, lane_up, phy_rst_n, lock_int, locklost_int, irq, pready);
        end
        #2;
        rst = 1'b0;
        tick(2);
        apb_read(13'h0, rd, err);
        n_vec++;
        if (rd !== 32'h0) begin
            n_err++; $display("FAIL async_rst_ctrl: got %h want 0", rd);
        end
        apb_read(13'h3, rd, err);
        n_vec++;
        if (rd !== 32'h0) begin
            n_err++; $display("FAIL async_rst_int_en: got %h want 0", rd);
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        test_reset();
        test_bring_up();
        test_lock_loss();
        test_w1c_race();
        test_fault();
        test_auto_retry();
        test_errors_and_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
